// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//   Decode stage of the RV32I five-stage pipeline. Holds the main/ALU decoder,
//   the immediate generator, the 32x32 register file with its write-back port
//   and the ID/EX pipeline register that feeds the execute stage.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous active-low reset
//   i_instD        instruction from the IF/ID register
//   i_PCD          PC of i_instD
//   i_PCPlus4D     i_PCD + 4
//   i_flushE       turn the next ID/EX contents into a bubble
//   i_RegWriteW    write-back enable
//   i_RdW          write-back destination register
//   i_ResultW      write-back data
//   o_rs1D/o_rs2D  combinational source indices for the hazard unit
//   o_RD1E/o_RD2E  registered register-file operands
//   o_ImmExtE      registered sign-extended immediate
//   o_PCE          registered PC
//   o_PCPlus4E     registered PC + 4
//   o_Rs1E/o_Rs2E/o_RdE  registered register indices
//   o_RegWriteE .. o_ALUSrcBE  registered single-bit controls
//   o_ResultSrcE   00 ALU, 01 memory, 10 PC+4
//   o_ALUControlE  registered ALU operation
//   o_funct3E      registered instD[14:12] (branch/load/store width)
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [31:0]     i_instD,
  input  logic [XLEN-1:0] i_PCD,
  input  logic [XLEN-1:0] i_PCPlus4D,
  input  logic            i_flushE,
  input  logic            i_RegWriteW,
  input  logic [4:0]      i_RdW,
  input  logic [XLEN-1:0] i_ResultW,
  output logic [4:0]      o_rs1D,
  output logic [4:0]      o_rs2D,
  output logic [XLEN-1:0] o_RD1E,
  output logic [XLEN-1:0] o_RD2E,
  output logic [XLEN-1:0] o_ImmExtE,
  output logic [XLEN-1:0] o_PCE,
  output logic [XLEN-1:0] o_PCPlus4E,
  output logic [4:0]      o_Rs1E,
  output logic [4:0]      o_Rs2E,
  output logic [4:0]      o_RdE,
  output logic            o_RegWriteE,
  output logic            o_MemWriteE,
  output logic            o_BranchE,
  output logic            o_JumpE,
  output logic            o_JalrE,
  output logic            o_ALUSrcAE,
  output logic            o_ALUSrcBE,
  output logic [1:0]      o_ResultSrcE,
  output logic [3:0]      o_ALUControlE,
  output logic [2:0]      o_funct3E
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RALU  = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_SLL   = 4'b0010,
    ALU_SLT   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_OR    = 4'b1000,
    ALU_AND   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_funct7b5;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic [XLEN-1:0] w_imm;
  alu_op_e         w_aluFunct;
  alu_op_e         w_aluControl;
  logic            w_regWrite;
  logic            w_memWrite;
  logic            w_branch;
  logic            w_jump;
  logic            w_jalr;
  logic            w_aluSrcA;
  logic            w_aluSrcB;
  logic [1:0]      w_resultSrc;

  logic [XLEN-1:0] r_regs [NREG];

  assign w_opcode   = i_instD[6:0];
  assign w_funct3   = i_instD[14:12];
  assign w_funct7b5 = i_instD[30];
  assign w_rd       = i_instD[11:7];
  assign o_rs1D     = i_instD[19:15];
  assign o_rs2D     = i_instD[24:20];

  // Register file storage. Entry 0 is only ever cleared; reads of x0 are
  // forced to zero below, so it never needs to hold anything else.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_RegWriteW && (i_RdW != 5'd0)) begin
      r_regs[i_RdW] <= i_ResultW;
    end
  end

  // Write-through: a write-back to the register being read this cycle is
  // forwarded, so write-back and decode can overlap without a stall.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (o_rs1D != 5'd0) begin
      w_rd1 = (i_RegWriteW && (i_RdW == o_rs1D)) ? i_ResultW : r_regs[o_rs1D];
    end
    if (o_rs2D != 5'd0) begin
      w_rd2 = (i_RegWriteW && (i_RdW == o_rs2D)) ? i_ResultW : r_regs[o_rs2D];
    end
  end

  always_comb begin
    w_imm = '0;
    unique case (w_opcode)
      OP_LOAD, OP_IALU, OP_JALR:
        w_imm = {{20{i_instD[31]}}, i_instD[31:20]};
      OP_STORE:
        w_imm = {{20{i_instD[31]}}, i_instD[31:25], i_instD[11:7]};
      OP_BR:
        w_imm = {{19{i_instD[31]}}, i_instD[31], i_instD[7],
                 i_instD[30:25], i_instD[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        w_imm = {i_instD[31:12], 12'b0};
      OP_JAL:
        w_imm = {{11{i_instD[31]}}, i_instD[31], i_instD[19:12],
                 i_instD[20], i_instD[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  // funct3/funct7 decode shared by R- and I-type ALU ops. For I-type, bit 30
  // is part of the immediate, so it only selects SUB for R-type; SRA is the
  // exception because srai carries funct7 in the same place.
  always_comb begin
    w_aluFunct = ALU_ADD;
    unique case (w_funct3)
      3'b000: w_aluFunct = (w_opcode == OP_RALU && w_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: w_aluFunct = ALU_SLL;
      3'b010: w_aluFunct = ALU_SLT;
      3'b011: w_aluFunct = ALU_SLTU;
      3'b100: w_aluFunct = ALU_XOR;
      3'b101: w_aluFunct = w_funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: w_aluFunct = ALU_OR;
      3'b111: w_aluFunct = ALU_AND;
      default: w_aluFunct = ALU_ADD;
    endcase
  end

  // Main decoder. Anything not listed keeps every control at zero and so
  // passes down the pipe as a NOP.
  always_comb begin
    w_regWrite   = 1'b0;
    w_memWrite   = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_jalr       = 1'b0;
    w_aluSrcA    = 1'b0;
    w_aluSrcB    = 1'b0;
    w_resultSrc  = 2'b00;
    w_aluControl = ALU_ADD;
    unique case (w_opcode)
      OP_RALU: begin
        w_regWrite   = 1'b1;
        w_aluControl = w_aluFunct;
      end
      OP_IALU: begin
        w_regWrite   = 1'b1;
        w_aluSrcB    = 1'b1;
        w_aluControl = w_aluFunct;
      end
      OP_LOAD: begin
        w_regWrite  = 1'b1;
        w_resultSrc = 2'b01;
        w_aluSrcB   = 1'b1;
      end
      OP_STORE: begin
        w_memWrite = 1'b1;
        w_aluSrcB  = 1'b1;
      end
      OP_BR: begin
        w_branch     = 1'b1;
        w_aluControl = ALU_SUB;
      end
      OP_JAL: begin
        w_jump      = 1'b1;
        w_regWrite  = 1'b1;
        w_resultSrc = 2'b10;
      end
      OP_JALR: begin
        w_jump      = 1'b1;
        w_jalr      = 1'b1;
        w_regWrite  = 1'b1;
        w_resultSrc = 2'b10;
        w_aluSrcB   = 1'b1;
      end
      OP_LUI: begin
        w_regWrite   = 1'b1;
        w_aluSrcB    = 1'b1;
        w_aluControl = ALU_PASSB;
      end
      OP_AUIPC: begin
        w_regWrite = 1'b1;
        w_aluSrcA  = 1'b1;
        w_aluSrcB  = 1'b1;
      end
      default: begin
        w_regWrite = 1'b0;
      end
    endcase
  end

  // ID/EX register. A bubble clears data fields as well as controls, which
  // makes flush and reset produce identical contents.
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_flushE) begin
      o_RD1E        <= '0;
      o_RD2E        <= '0;
      o_ImmExtE     <= '0;
      o_PCE         <= '0;
      o_PCPlus4E    <= '0;
      o_Rs1E        <= '0;
      o_Rs2E        <= '0;
      o_RdE         <= '0;
      o_RegWriteE   <= 1'b0;
      o_MemWriteE   <= 1'b0;
      o_BranchE     <= 1'b0;
      o_JumpE       <= 1'b0;
      o_JalrE       <= 1'b0;
      o_ALUSrcAE    <= 1'b0;
      o_ALUSrcBE    <= 1'b0;
      o_ResultSrcE  <= 2'b00;
      o_ALUControlE <= 4'b0000;
      o_funct3E     <= 3'b000;
    end else begin
      o_RD1E        <= w_rd1;
      o_RD2E        <= w_rd2;
      o_ImmExtE     <= w_imm;
      o_PCE         <= i_PCD;
      o_PCPlus4E    <= i_PCPlus4D;
      o_Rs1E        <= o_rs1D;
      o_Rs2E        <= o_rs2D;
      o_RdE         <= w_rd;
      o_RegWriteE   <= w_regWrite;
      o_MemWriteE   <= w_memWrite;
      o_BranchE     <= w_branch;
      o_JumpE       <= w_jump;
      o_JalrE       <= w_jalr;
      o_ALUSrcAE    <= w_aluSrcA;
      o_ALUSrcBE    <= w_aluSrcB;
      o_ResultSrcE  <= w_resultSrc;
      o_ALUControlE <= w_aluControl;
      o_funct3E     <= w_funct3;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
//   Table-driven bench for id_stage. Each record holds the inputs for one
//   cycle and the expected decode; expected ID/EX contents are queued when a
//   record is driven and popped after the following rising edge.
//   Control bits are packed for comparison as
//   {RegWrite, MemWrite, Branch, Jump, Jalr, ALUSrcA, ALUSrcB,
//    ResultSrc[1:0], ALUControl[3:0], funct3[2:0]}.
// ---------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instD;
  logic [31:0] pcD;
  logic [31:0] pcPlus4D;
  logic        flushE;
  logic        regWriteW;
  logic [4:0]  rdW;
  logic [31:0] resultW;
  logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE;
  logic [31:0] rd1E, rd2E, immExtE, pcE, pcPlus4E;
  logic        regWriteE, memWriteE, branchE, jumpE, jalrE, aluSrcAE, aluSrcBE;
  logic [1:0]  resultSrcE;
  logic [3:0]  aluControlE;
  logic [2:0]  funct3E;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [31:0] instD;
    logic [31:0] pcD;
    logic        regWriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;
    logic [15:0] expCtrl;
    logic [31:0] expRd1;
    logic [31:0] expRd2;
    logic [31:0] expImm;
    logic [4:0]  expRs1;
    logic [4:0]  expRs2;
    logic [4:0]  expRd;
  } vec_t;

  typedef struct {
    logic [15:0] ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [14:0] idx;
  } exp_t;

  vec_t vecs[$];
  exp_t scoreboard[$];
  int   assertCount = 0;
  int   failCount   = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_instD       (instD),
    .i_PCD         (pcD),
    .i_PCPlus4D    (pcPlus4D),
    .i_flushE      (flushE),
    .i_RegWriteW   (regWriteW),
    .i_RdW         (rdW),
    .i_ResultW     (resultW),
    .o_rs1D        (rs1D),
    .o_rs2D        (rs2D),
    .o_RD1E        (rd1E),
    .o_RD2E        (rd2E),
    .o_ImmExtE     (immExtE),
    .o_PCE         (pcE),
    .o_PCPlus4E    (pcPlus4E),
    .o_Rs1E        (rs1E),
    .o_Rs2E        (rs2E),
    .o_RdE         (rdE),
    .o_RegWriteE   (regWriteE),
    .o_MemWriteE   (memWriteE),
    .o_BranchE     (branchE),
    .o_JumpE       (jumpE),
    .o_JalrE       (jalrE),
    .o_ALUSrcAE    (aluSrcAE),
    .o_ALUSrcBE    (aluSrcBE),
    .o_ResultSrcE  (resultSrcE),
    .o_ALUControlE (aluControlE),
    .o_funct3E     (funct3E)
  );

  function automatic vec_t mkVec(
    input logic r, input logic f, input logic [31:0] inst, input logic [31:0] pc,
    input logic w, input logic [4:0] rdw, input logic [31:0] res,
    input logic [15:0] ctrl, input logic [31:0] rd1, input logic [31:0] rd2,
    input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd);
    vec_t v;
    v.rst = r; v.flush = f; v.instD = inst; v.pcD = pc;
    v.regWriteW = w; v.rdW = rdw; v.resultW = res;
    v.expCtrl = ctrl; v.expRd1 = rd1; v.expRd2 = rd2; v.expImm = imm;
    v.expRs1 = rs1; v.expRs2 = rs2; v.expRd = rd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int vecIdx,
                             input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s (vector %0d): got %h, expected %h", name, vecIdx, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int vecIdx);
    exp_t e;
    logic bubble;
    @(negedge clk);
    rst       = v.rst;
    flushE    = v.flush;
    instD     = v.instD;
    pcD       = v.pcD;
    pcPlus4D  = v.pcD + 32'd4;
    regWriteW = v.regWriteW;
    rdW       = v.rdW;
    resultW   = v.resultW;
    #1;
    checkOutput("rs1D", vecIdx, {27'b0, rs1D}, {27'b0, v.expRs1});
    checkOutput("rs2D", vecIdx, {27'b0, rs2D}, {27'b0, v.expRs2});
    bubble = !v.rst || v.flush;
    e.ctrl = bubble ? 16'h0 : v.expCtrl;
    e.rd1  = bubble ? 32'h0 : v.expRd1;
    e.rd2  = bubble ? 32'h0 : v.expRd2;
    e.imm  = bubble ? 32'h0 : v.expImm;
    e.pc   = bubble ? 32'h0 : v.pcD;
    e.pc4  = bubble ? 32'h0 : v.pcD + 32'd4;
    e.idx  = bubble ? 15'h0 : {v.expRs1, v.expRs2, v.expRd};
    scoreboard.push_back(e);
  endtask

  task automatic compareE(input int vecIdx);
    exp_t e;
    @(posedge clk);
    #1;
    if (scoreboard.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard (vector %0d): got empty queue, expected an entry", vecIdx);
    end else begin
      e = scoreboard.pop_front();
      checkOutput("ctrl", vecIdx,
        {16'b0, regWriteE, memWriteE, branchE, jumpE, jalrE, aluSrcAE, aluSrcBE,
         resultSrcE, aluControlE, funct3E}, {16'b0, e.ctrl});
      checkOutput("RD1E", vecIdx, rd1E, e.rd1);
      checkOutput("RD2E", vecIdx, rd2E, e.rd2);
      checkOutput("ImmExtE", vecIdx, immExtE, e.imm);
      checkOutput("PCE", vecIdx, pcE, e.pc);
      checkOutput("PCPlus4E", vecIdx, pcPlus4E, e.pc4);
      checkOutput("Rs1E/Rs2E/RdE", vecIdx, {17'b0, rs1E, rs2E, rdE}, {17'b0, e.idx});
    end
  endtask

  initial begin
    logic [4:0] r;
    rst = 1'b0; flushE = 1'b0; instD = 32'h0; pcD = 32'h0; pcPlus4D = 32'h4;
    regWriteW = 1'b0; rdW = 5'd0; resultW = 32'h0;

    // Two reset cycles; the write-back to x7 must lose to reset.
    vecs.push_back(mkVec(0, 0, 32'h00500093, 32'h100, 1, 5'd7, 32'h55,
                         16'h0, 0, 0, 0, 5'd0, 5'd5, 5'd1));
    vecs.push_back(mkVec(0, 0, 32'h00500093, 32'h100, 1, 5'd7, 32'h55,
                         16'h0, 0, 0, 0, 5'd0, 5'd5, 5'd1));
    // Read every register after reset with add x0,xi,xi.
    for (int i = 1; i < 32; i++) begin
      r = i[4:0];
      vecs.push_back(mkVec(1, 0, {7'b0, r, r, 3'b000, 5'd0, 7'b0110011}, 32'h0, 0, 5'd0, 0,
                           16'h8000, 0, 0, 0, r, r, 5'd0));
    end
    // addi x1,x0,5
    vecs.push_back(mkVec(1, 0, 32'h00500093, 32'h10, 0, 0, 0, 16'h8200, 0, 0, 5, 0, 5, 1));
    // add x4,x3,x0 with simultaneous write-back of x3
    vecs.push_back(mkVec(1, 0, 32'h00018233, 32'h14, 1, 3, 32'hDEADBEEF,
                         16'h8000, 32'hDEADBEEF, 0, 0, 3, 0, 4));
    // add x4,x3,x3 reads the committed value
    vecs.push_back(mkVec(1, 0, 32'h00318233, 32'h18, 0, 0, 0,
                         16'h8000, 32'hDEADBEEF, 32'hDEADBEEF, 0, 3, 3, 4));
    // write x0 with 5 while reading x0, then read x0 again (and load x1)
    vecs.push_back(mkVec(1, 0, 32'h00000033, 32'h1C, 1, 0, 5, 16'h8000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 0, 32'h00000033, 32'h20, 1, 1, 32'h11111111,
                         16'h8000, 0, 0, 0, 0, 0, 0));
    // beq x1,x2,-8
    vecs.push_back(mkVec(1, 0, 32'hFE208CE3, 32'h200, 0, 0, 0,
                         16'h2008, 32'h11111111, 0, 32'hFFFFFFF8, 1, 2, 25));
    // flushed addi while x2 is written, then the same addi unflushed
    vecs.push_back(mkVec(1, 1, 32'h00500093, 32'h24, 1, 2, 32'h22222222,
                         16'h8200, 0, 0, 5, 0, 5, 1));
    vecs.push_back(mkVec(1, 0, 32'h00500093, 32'h24, 0, 0, 0, 16'h8200, 0, 0, 5, 0, 5, 1));
    // add x0,x1,x2 confirms the write under flush committed
    vecs.push_back(mkVec(1, 0, 32'h00208033, 32'h28, 0, 0, 0,
                         16'h8000, 32'h11111111, 32'h22222222, 0, 1, 2, 0));
    // lui x1,0x12345 ; jal x1,+16 ; auipc x5,1
    vecs.push_back(mkVec(1, 0, 32'h123450B7, 32'h100, 0, 0, 0,
                         16'h8255, 0, 32'hDEADBEEF, 32'h12345000, 8, 3, 1));
    vecs.push_back(mkVec(1, 0, 32'h010000EF, 32'h100, 0, 0, 0,
                         16'h9100, 0, 0, 32'h10, 0, 16, 1));
    vecs.push_back(mkVec(1, 0, 32'h00001297, 32'h300, 0, 0, 0,
                         16'h8601, 0, 0, 32'h1000, 0, 0, 5));
    // lw x6,-4(x1) ; sw x2,8(x1) ; jalr x1,4(x2)
    vecs.push_back(mkVec(1, 0, 32'hFFC0A303, 32'h304, 0, 0, 0,
                         16'h8282, 32'h11111111, 0, 32'hFFFFFFFC, 1, 28, 6));
    vecs.push_back(mkVec(1, 0, 32'h0020A423, 32'h308, 0, 0, 0,
                         16'h4202, 32'h11111111, 32'h22222222, 8, 1, 2, 8));
    vecs.push_back(mkVec(1, 0, 32'h004100E7, 32'h30C, 0, 0, 0,
                         16'h9B00, 32'h22222222, 0, 4, 2, 4, 1));
    // srai x7,x2,3 ; sub x8,x1,x2 ; addi x9,x0,-1024 (bit 30 set, still ADD)
    vecs.push_back(mkVec(1, 0, 32'h40315393, 32'h310, 0, 0, 0,
                         16'h823D, 32'h22222222, 32'hDEADBEEF, 32'h403, 2, 3, 7));
    vecs.push_back(mkVec(1, 0, 32'h40208433, 32'h314, 0, 0, 0,
                         16'h8008, 32'h11111111, 32'h22222222, 0, 1, 2, 8));
    vecs.push_back(mkVec(1, 0, 32'hC0000493, 32'h318, 0, 0, 0,
                         16'h8200, 0, 0, 32'hFFFFFC00, 0, 0, 9));
    // and x10 ; or x11 ; slt x11
    vecs.push_back(mkVec(1, 0, 32'h0020F533, 32'h31C, 0, 0, 0,
                         16'h804F, 32'h11111111, 32'h22222222, 0, 1, 2, 10));
    vecs.push_back(mkVec(1, 0, 32'h0020E5B3, 32'h320, 0, 0, 0,
                         16'h8046, 32'h11111111, 32'h22222222, 0, 1, 2, 11));
    vecs.push_back(mkVec(1, 0, 32'h0020A5B3, 32'h324, 0, 0, 0,
                         16'h801A, 32'h11111111, 32'h22222222, 0, 1, 2, 11));
    // unknown opcode 0x7F: controls zero, data still registered
    vecs.push_back(mkVec(1, 0, 32'h0020807F, 32'h328, 0, 0, 0,
                         16'h0000, 32'h11111111, 32'h22222222, 0, 1, 2, 0));
    // second reset clears written registers
    vecs.push_back(mkVec(0, 0, 32'h00000033, 32'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 0, 32'h00118033, 32'h40, 0, 0, 0, 16'h8000, 0, 0, 0, 3, 1, 0));

    $display("[TB] applying %0d vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i], i);
      compareE(i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the RV32I 5-stage pipeline. Sits directly downstream of the fetch stage and consumes its instD/PCD/PCPlus4D.
- Contains the main/ALU decoder, the immediate generator and the 32x32 register file with a write-back port.
- Contains the ID/EX pipeline register, which feeds the execute stage.
- Exposes combinational rs1D/rs2D to the hazard unit. Accepts flushE for load-use bubbles and taken branches.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, register file depth (x0 hardwired to zero).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- instD  in  32  instruction from the IF/ID register.
- PCD  in  32  PC of instD.
- PCPlus4D  in  32  PCD+4.
- flushE  in  1  insert bubble into the ID/EX register.
- RegWriteW  in  1  write-back enable.
- RdW  in  5  write-back destination.
- ResultW  in  32  write-back data.
- rs1D  out  5  instD[19:15], combinational.
- rs2D  out  5  instD[24:20], combinational.
- RD1E, RD2E  out  32 each  registered operands.
- ImmExtE  out  32  registered sign-extended immediate.
- PCE, PCPlus4E  out  32 each  registered PC values.
- Rs1E, Rs2E, RdE  out  5 each  registered register indices.
- RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcAE, ALUSrcBE  out  1 each  registered controls.
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlE  out  4  registered ALU operation.
- funct3E  out  3  registered instD[14:12], used for branch, load and store width.

Behaviour:
- Register file: two asynchronous reads and one write on the clk rising edge when RegWriteW=1 and RdW!=0.
  - Writes to x0 are ignored; a read of x0 always returns 0.
  - Write-through bypass: if RegWriteW=1, RdW!=0 and RdW equals the read index, that read returns ResultW in the same cycle.
- Immediate generation by opcode, all sign-extended from bit 31:
  - I (0000011, 0010011, 1100111).
  - S (0100011).
  - B (1100011), bit0=0.
  - U (0110111, 0010111), low 12 bits zero.
  - J (1101111), bit0=0.
  - R-type: immediate is 0.
- Decoder by opcode:
  - R/I-ALU: RegWrite=1, ALUSrcB=imm for I.
  - Load: RegWrite=1, ResultSrc=01, ALUSrcB=1, ADD.
  - Store: MemWrite=1, ALUSrcB=1, ADD.
  - Branch: Branch=1, SUB.
  - JAL: Jump=1, RegWrite=1, ResultSrc=10.
  - JALR: Jump=1, Jalr=1, RegWrite=1, ResultSrc=10, ALUSrcB=1, ADD.
  - LUI: RegWrite=1, ALUSrcB=1, ALU=PASSB.
  - AUIPC: RegWrite=1, ALUSrcA=PC, ALUSrcB=1, ADD.
- ALUControl encoding: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASSB.
  - SUB applies only for R-type with funct7[5]=1.
  - SRA applies when funct3=101 and funct7[5]=1, for both R- and I-type.
- Unknown opcode: all control bits 0, so the instruction acts as a NOP. Data fields are still registered.
- ID/EX register, latency 1: values decoded in cycle N appear on the E outputs in cycle N+1.
- rst=0 at a clock edge: all E outputs go to 0 and all 31 writable registers go to 0. Reset has priority over flushE and over a write-back on that edge.
- flushE=1 (with rst=1): all E control outputs go to 0 (RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcAE, ALUSrcBE, ResultSrcE, ALUControlE, funct3E). RdE, Rs1E and Rs2E go to 0. Data fields are don't-care, driven to 0.
- flushE and a register-file write in the same cycle: the write still commits.
- No stall input. The ID/EX register updates every cycle. Holding instD during a stall is the responsibility of the IF/ID register.

Test Plan:
- Reset: drive rst=0 for 2 cycles with instD=0x00500093 → all E outputs 0. Then read x1..x31 → all 0.
- addi x1,x0,5: instD=0x00500093 → next cycle RdE=1, Rs1E=0, ImmExtE=5, RegWriteE=1, ALUSrcBE=1, ALUControlE=0000, ResultSrcE=00, RD1E=0.
- Write-through bypass: RegWriteW=1, RdW=3, ResultW=0xDEADBEEF, and instD=0x00018233 (add x4,x3,x0) in the same cycle → next cycle RD1E=0xDEADBEEF, RdE=4. Then write x0 with 5, read x0 → 0.
- Branch immediate: instD=0xFE208CE3 (beq x1,x2,-8) → ImmExtE=0xFFFFFFF8, BranchE=1, RegWriteE=0, ALUControlE=0001, Rs1E=1, Rs2E=2, funct3E=000.
- Flush: present the addi from the second scenario with flushE=1 → next cycle RegWriteE=0, ALUControlE=0, RdE=0. On the following cycle with flushE=0, the normal decode reappears.
- Upper and jump forms, with PCD=0x100 and PCPlus4D=0x104:
  - LUI 0x12345 (0x123450B7) → ImmExtE=0x12345000, ALUControlE=1010.
  - JAL x1,+16 (0x010000EF) → ImmExtE=0x10, JumpE=1, ResultSrcE=10, PCPlus4E=0x104.
  - Opcode 0x7F → all control outputs 0.
